draw_hearts: RTL and testbench
==============================

// Module: draw_hearts
// PURPOSE
//  Paints the heart (life) icons for both tanks into the VGA frame buffer.
//  Counterpart of the heart-erase path: erase blanks one slot on a hit; this block draws all live slots.
//  It runs on game start, round restart or full-screen redraw.
//  Sits beside the other sprite drawers; its ox/oy/ocolor_out/owriteEn go to the shared VGA write mux.
// PARAMETERS
//  P1_X        5       left x of player-1 heart column
//  P2_X        298     left x of player-2 heart column
//  SLOT_Y0     86      top y of slot 0 (lowest life index)
//  SLOT_PITCH  18      y distance between slots (slot k top = SLOT_Y0 + k*SLOT_PITCH)
//  HEART_COLOR 3'b100  colour of sprite '1' pixels
//  BG_COLOR    3'b111  colour of sprite '0' pixels (matches erase colour)
// PORTS
//  iCLOCK_50   in  1  system clock, 50 MHz
//  ireset      in  1  synchronous reset, active-high
//  iDrawHearts in  1  start request; sampled only in IDLE
//  iP1Life     in  2  player-1 lives (0..3); latched at start
//  iP2Life     in  2  player-2 lives (0..3); latched at start
//  ocolor_out  out 3  pixel colour
//  ox          out 9  pixel x
//  oy          out 8  pixel y
//  owriteEn    out 1  frame-buffer write strobe
//  oBusy       out 1  high whenever state != IDLE
//  oDoneSignal out 1  one-cycle pulse when all slots are drawn
// BEHAVIOUR
//  - Reset: state=IDLE; owriteEn=0, oDoneSignal=0, oBusy=0, ox=0, oy=0, ocolor_out=BG_COLOR. Counters are cleared.
//  - Reset mid-draw: abort, return to IDLE, no done pulse, owriteEn=0 the next cycle.
//  - Slot k of a player is drawn iff k < latched life. Lives=3 draws 3 hearts; lives=0 draws none.
//  - Order: P1 slots 0,1,2, then P2 slots 0,1,2. Skipped slots cost 0 cycles.
//  - FSM (all outputs registered):
//    - IDLE: if iDrawHearts, latch lives, clear the slot pointer, go to SELECT.
//    - SELECT: advance to the next valid slot. Go to SETUP; if none is left, go to DONE.
//    - SETUP: load the slot base x/y, x_cnt=0, y_cnt=0, go to DRAW.
//    - DRAW: owriteEn=1; ox=base_x+x_cnt, oy=base_y+y_cnt. ocolor_out = sprite[y_cnt][x_cnt] ? HEART_COLOR : BG_COLOR.
//      If x_cnt==15 and y_cnt==15, go to SELECT; else go to COUNT.
//    - COUNT: owriteEn=0. x_cnt++; on 15, wrap to 0 and y_cnt++. Go to DRAW.
//    - DONE: oDoneSignal=1 for exactly one cycle, then IDLE.
//  - Counters are 4-bit, raster order x-fastest. Base+offset is computed at ox/oy width (no overflow for the defaults).
//  - Each heart takes 1 SETUP + 256 DRAW + 255 COUNT = 512 cycles, plus 1 SELECT per heart and 1 final SELECT.
//  - Total for N hearts = 1 + N*513 + 1 (DONE) cycles after the start edge.
//  - Simultaneous events:
//    - iDrawHearts held high re-triggers only after returning to IDLE.
//    - Life inputs changing while busy are ignored.
//    - iDrawHearts in the same cycle as ireset is ignored.
// CONFIGURATION
//  HEART_TRANSPARENT_EN defined:
//    - In DRAW, owriteEn=1 only for sprite '1' pixels; '0' pixels are skipped, leaving the background intact.
//    - DRAW/COUNT timing is unchanged (cycle counts identical).
//  HEART_TRANSPARENT_EN undefined: every pixel is written; '0' pixels use BG_COLOR.
// STRUCTURE
//  Package tank_gfx_pkg holds:
//    - the 16x16 heart bitmap constant;
//    - P1_X/P2_X/SLOT_Y0/SLOT_PITCH defaults;
//    - colour constants;
//    - the state encoding shared with the erase block.
//  Sub-module heart_sprite_rom: combinational (x_cnt,y_cnt) -> 1-bit pixel. It is shared with any future heart animation.
//  The top module holds the FSM, slot pointer, counters and output registers.
// TESTING
//  1. P1Life=3, P2Life=3, pulse start -> 6*256 writes; oDoneSignal pulses at cycle 3080.
//     First write is (5,86); last P1 write is (20,137); last write is (313,137).
//  2. P1Life=0, P2Life=0, start -> no owriteEn; oDoneSignal pulses 2 cycles after start; oBusy high for 2 cycles.
//  3. P1Life=1, P2Life=2 -> writes only in y 86..101 for P1 and y 86..119 for P2; 768 writes total.
//     Every write's ocolor_out matches the bitmap.
//  4. Assert ireset during P1 slot 1 -> owriteEn=0 next cycle, no done pulse; a new start redraws from (5,86).
//  5. Change iP1Life 3->0 mid-draw and hold iDrawHearts high -> the current draw completes with lives=3, then a second pass begins.
//  6. HEART_TRANSPARENT_EN defined, lives 1/0 -> write count equals the bitmap popcount; done timing is the same as without the macro.

Source files
------------

// File: rtl/tank_gfx_pkg.sv
// Shared tank-game graphics definitions: heart bitmap, slot geometry,
// colours and the draw/erase FSM state encoding.
package tank_gfx_pkg;

  // Slot geometry defaults
  localparam logic [8:0] P1_X_DEF       = 9'd5;
  localparam logic [8:0] P2_X_DEF       = 9'd298;
  localparam logic [7:0] SLOT_Y0_DEF    = 8'd86;
  localparam logic [7:0] SLOT_PITCH_DEF = 8'd18;

  // Colours: background matches the heart-erase colour
  localparam logic [2:0] HEART_COLOR_DEF = 3'b100;
  localparam logic [2:0] BG_COLOR_DEF    = 3'b111;

  // State encoding shared with the heart-erase block
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SELECT = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_DRAW   = 3'd3;
  localparam logic [2:0] ST_COUNT  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // 16x16 heart, row 0 on top, MSB of each row is the leftmost pixel
  localparam logic [0:15][15:0] HEART_BITMAP = {
    16'h0000, 16'h3838, 16'h7C7C, 16'hFEFE,
    16'hFFFE, 16'hFFFE, 16'hFFFE, 16'h7FFC,
    16'h3FF8, 16'h1FF0, 16'h0FE0, 16'h07C0,
    16'h0380, 16'h0100, 16'h0000, 16'h0000
  };

  // Look up one bitmap pixel by column/row offset inside the sprite
  function automatic logic heart_pixel(input logic [3:0] x, input logic [3:0] y);
    return HEART_BITMAP[y][4'd15 - x];
  endfunction

endpackage

// File: rtl/heart_sprite_rom.sv
// Combinational heart sprite lookup: (x_cnt, y_cnt) -> pixel bit.
// Kept separate so a future heart animation can share it.
module heart_sprite_rom
  import tank_gfx_pkg::*;
(
  input  logic [3:0] x_cnt,
  input  logic [3:0] y_cnt,
  output logic       pixel
);

  assign pixel = heart_pixel(x_cnt, y_cnt);

endmodule

// File: rtl/draw_hearts.sv
// Paints every live heart slot for both tanks into the frame buffer.
// Order is P1 slots 0..2 then P2 slots 0..2; dead slots are skipped
// inside a single SELECT cycle.
// Optional build macro HEART_TRANSPARENT_EN: only '1' sprite pixels are
// written, leaving the background intact; cycle timing is unchanged.
module draw_hearts
  import tank_gfx_pkg::*;
#(
  parameter logic [8:0] P1_X        = P1_X_DEF,
  parameter logic [8:0] P2_X        = P2_X_DEF,
  parameter logic [7:0] SLOT_Y0     = SLOT_Y0_DEF,
  parameter logic [7:0] SLOT_PITCH  = SLOT_PITCH_DEF,
  parameter logic [2:0] HEART_COLOR = HEART_COLOR_DEF,
  parameter logic [2:0] BG_COLOR    = BG_COLOR_DEF
)(
  input  logic       iCLOCK_50,
  input  logic       ireset,
  input  logic       iDrawHearts,
  input  logic [1:0] iP1Life,
  input  logic [1:0] iP2Life,
  output logic [2:0] ocolor_out,
  output logic [8:0] ox,
  output logic [7:0] oy,
  output logic       owriteEn,
  output logic       oBusy,
  output logic       oDoneSignal
);

  logic [2:0] state;
  logic [2:0] slot_ptr;
  logic [1:0] p1_life;
  logic [1:0] p2_life;
  logic [3:0] x_cnt;
  logic [3:0] y_cnt;
  logic [8:0] base_x;
  logic [7:0] base_y;

  logic [5:0] slot_valid;
  logic       next_found;
  logic [2:0] next_slot;
  logic [1:0] slot_row;
  logic [8:0] base_x_nxt;
  logic [7:0] base_y_nxt;
  logic       sprite_pixel;
  logic       pix_we;
  logic [2:0] pix_color;

  heart_sprite_rom u_rom (
    .x_cnt (x_cnt),
    .y_cnt (y_cnt),
    .pixel (sprite_pixel)
  );

  assign pix_color = sprite_pixel ? HEART_COLOR : BG_COLOR;

`ifdef HEART_TRANSPARENT_EN
  assign pix_we = sprite_pixel;
`else
  assign pix_we = 1'b1;
`endif

  // A slot is live when its row index is below the latched life count
  always_comb begin
    slot_valid = '0;
    for (int k = 0; k < 3; k++) begin
      slot_valid[k]     = (2'(k) < p1_life);
      slot_valid[k + 3] = (2'(k) < p2_life);
    end
  end

  // Lowest live slot at or after the pointer; searched downward so the lowest wins
  always_comb begin
    next_found = 1'b0;
    next_slot  = slot_ptr;
    for (int s = 5; s >= 0; s--) begin
      if (slot_valid[s] && (3'(s) >= slot_ptr)) begin
        next_found = 1'b1;
        next_slot  = 3'(s);
      end
    end
  end

  // Screen origin of the slot the pointer currently selects
  always_comb begin
    if (slot_ptr < 3'd3) begin
      base_x_nxt = P1_X;
      slot_row   = slot_ptr[1:0];
    end else begin
      base_x_nxt = P2_X;
      slot_row   = 2'(slot_ptr - 3'd3);
    end
    base_y_nxt = SLOT_Y0 + SLOT_PITCH * {6'd0, slot_row};
  end

  // Main FSM with registered pixel outputs
  always_ff @(posedge iCLOCK_50) begin
    if (ireset) begin
      state       <= ST_IDLE;
      slot_ptr    <= '0;
      p1_life     <= '0;
      p2_life     <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      base_x      <= '0;
      base_y      <= '0;
      ox          <= '0;
      oy          <= '0;
      ocolor_out  <= BG_COLOR;
      owriteEn    <= 1'b0;
      oBusy       <= 1'b0;
      oDoneSignal <= 1'b0;
    end else begin
      oDoneSignal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iDrawHearts) begin
            p1_life  <= iP1Life;
            p2_life  <= iP2Life;
            slot_ptr <= '0;
            oBusy    <= 1'b1;
            state    <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          x_cnt <= '0;
          y_cnt <= '0;
          if (next_found) begin
            slot_ptr <= next_slot;
            state    <= ST_SETUP;
          end else begin
            oDoneSignal <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_SETUP: begin
          base_x     <= base_x_nxt;
          base_y     <= base_y_nxt;
          x_cnt      <= '0;
          y_cnt      <= '0;
          ox         <= base_x_nxt;
          oy         <= base_y_nxt;
          ocolor_out <= pix_color;
          owriteEn   <= pix_we;
          state      <= ST_DRAW;
        end
        ST_DRAW: begin
          owriteEn <= 1'b0;
          if ((x_cnt == 4'd15) && (y_cnt == 4'd15)) begin
            slot_ptr <= slot_ptr + 3'd1;
            state    <= ST_SELECT;
          end else begin
            x_cnt <= x_cnt + 4'd1;
            if (x_cnt == 4'd15) begin
              y_cnt <= y_cnt + 4'd1;
            end
            state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          ox         <= base_x + {5'd0, x_cnt};
          oy         <= base_y + {4'd0, y_cnt};
          ocolor_out <= pix_color;
          owriteEn   <= pix_we;
          state      <= ST_DRAW;
        end
        ST_DONE: begin
          oBusy <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          owriteEn <= 1'b0;
          oBusy    <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_hearts.sv
// Self-checking bench for draw_hearts. Expected pixel streams come from a
// raster model built straight from the slot geometry and heart bitmap.
`timescale 1ns/1ps
module tb_draw_hearts;

  logic       iCLOCK_50 = 1'b0;
  logic       ireset;
  logic       iDrawHearts;
  logic [1:0] iP1Life;
  logic [1:0] iP2Life;
  logic [2:0] ocolor_out;
  logic [8:0] ox;
  logic [7:0] oy;
  logic       owriteEn;
  logic       oBusy;
  logic       oDoneSignal;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] HEART_ROWS [16] = '{
    16'h0000, 16'h3838, 16'h7C7C, 16'hFEFE,
    16'hFFFE, 16'hFFFE, 16'hFFFE, 16'h7FFC,
    16'h3FF8, 16'h1FF0, 16'h0FE0, 16'h07C0,
    16'h0380, 16'h0100, 16'h0000, 16'h0000
  };

  int heartPop;
  int perHeart;

  int expX[$], expY[$], expC[$];
  int obsX[$], obsY[$], obsC[$];
  int doneCyc, doneCnt, busyCyc;
  bit timedOut;

  draw_hearts dut (
    .iCLOCK_50   (iCLOCK_50),
    .ireset      (ireset),
    .iDrawHearts (iDrawHearts),
    .iP1Life     (iP1Life),
    .iP2Life     (iP2Life),
    .ocolor_out  (ocolor_out),
    .ox          (ox),
    .oy          (oy),
    .owriteEn    (owriteEn),
    .oBusy       (oBusy),
    .oDoneSignal (oDoneSignal)
  );

  always #10 iCLOCK_50 = ~iCLOCK_50;

  // Reference raster: every live slot, row by row, x fastest
  task automatic buildExpected(input int p1, input int p2);
    int lives;
    int bx;
    bit on;
    expX.delete(); expY.delete(); expC.delete();
    for (int p = 0; p < 2; p++) begin
      lives = (p == 0) ? p1 : p2;
      bx    = (p == 0) ? 5 : 298;
      for (int k = 0; k < lives; k++)
        for (int y = 0; y < 16; y++)
          for (int x = 0; x < 16; x++) begin
            on = HEART_ROWS[y][15 - x];
`ifdef HEART_TRANSPARENT_EN
            if (on) begin
              expX.push_back(bx + x); expY.push_back(86 + 18 * k + y); expC.push_back(4);
            end
`else
            expX.push_back(bx + x); expY.push_back(86 + 18 * k + y); expC.push_back(on ? 4 : 7);
`endif
          end
    end
  endtask

  // Index of the first difference between observed and expected streams, -1 if identical
  function automatic int firstSeqDiff();
    int n;
    n = (obsX.size() < expX.size()) ? obsX.size() : expX.size();
    for (int i = 0; i < n; i++)
      if (obsX[i] != expX[i] || obsY[i] != expY[i] || obsC[i] != expC[i]) return i;
    if (obsX.size() != expX.size()) return n;
    return -1;
  endfunction

  function automatic string seqAt(input int i, input bit useObs);
    if (useObs) return (i < obsX.size()) ? $sformatf("(%0d,%0d,c%0d)", obsX[i], obsY[i], obsC[i]) : "none";
    return (i < expX.size()) ? $sformatf("(%0d,%0d,c%0d)", expX[i], expY[i], expC[i]) : "none";
  endfunction

  // Pulse start for one cycle and record everything up to shortly after done
  task automatic applyStimulus(input int p1, input int p2, input int budget);
    int k;
    obsX.delete(); obsY.delete(); obsC.delete();
    doneCyc = -1; doneCnt = 0; busyCyc = 0; timedOut = 0; k = 0;
    @(negedge iCLOCK_50);
    iP1Life = 2'(p1); iP2Life = 2'(p2); iDrawHearts = 1'b1;
    while (1) begin
      @(negedge iCLOCK_50);
      iDrawHearts = 1'b0;
      k++;
      if (owriteEn) begin
        obsX.push_back(int'(ox)); obsY.push_back(int'(oy)); obsC.push_back(int'(ocolor_out));
      end
      if (oBusy) busyCyc++;
      if (oDoneSignal) begin doneCnt++; doneCyc = k; end
      if (doneCnt > 0 && k >= doneCyc + 3) break;
      if (k >= budget) begin timedOut = 1; break; end
    end
  endtask

  task automatic test_reset();
    ireset = 1'b1; iDrawHearts = 1'b1; iP1Life = 2'd3; iP2Life = 2'd3;
    repeat (3) @(posedge iCLOCK_50);
    @(negedge iCLOCK_50);
    checks++;
    if ({owriteEn, oDoneSignal, oBusy} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_strobes: got we/done/busy=%b expected 000", {owriteEn, oDoneSignal, oBusy});
    end
    checks++;
    if (ox !== 9'd0 || oy !== 8'd0) begin
      errors++; $display("[TB] FAIL reset_xy: got (%0d,%0d) expected (0,0)", ox, oy);
    end
    checks++;
    if (ocolor_out !== 3'b111) begin
      errors++; $display("[TB] FAIL reset_color: got %b expected 111", ocolor_out);
    end
    iDrawHearts = 1'b0; ireset = 1'b0;
    @(negedge iCLOCK_50);
    checks++;
    if (oBusy !== 1'b0) begin
      errors++; $display("[TB] FAIL start_during_reset: got busy=%b expected 0", oBusy);
    end
  endtask

  task automatic test_full_lives();
    int d;
    buildExpected(3, 3);
    applyStimulus(3, 3, 4000);
    checks++;
    if (timedOut) begin errors++; $display("[TB] FAIL full_timeout: got no done expected done by cycle 3080"); end
    d = firstSeqDiff();
    checks++;
    if (d != -1) begin errors++; $display("[TB] FAIL full_stream: at write %0d got %s expected %s", d, seqAt(d, 1), seqAt(d, 0)); end
    checks++;
    if (obsX.size() != 6 * perHeart) begin errors++; $display("[TB] FAIL full_count: got %0d expected %0d", obsX.size(), 6 * perHeart); end
    checks++;
    if (doneCyc != 3080 || doneCnt != 1) begin errors++; $display("[TB] FAIL full_done: got cycle %0d count %0d expected cycle 3080 count 1", doneCyc, doneCnt); end
    checks++;
    if (busyCyc != 3080) begin errors++; $display("[TB] FAIL full_busy: got %0d expected 3080", busyCyc); end
`ifndef HEART_TRANSPARENT_EN
    checks++;
    if (obsX.size() != 1536 || obsX[0] != 5 || obsY[0] != 86 || obsX[767] != 20 || obsY[767] != 137 ||
        obsX[1535] != 313 || obsY[1535] != 137) begin
      errors++; $display("[TB] FAIL full_corners: got first %s p1last %s last %s expected (5,86) (20,137) (313,137)",
                         seqAt(0, 1), seqAt(767, 1), seqAt(1535, 1));
    end
`endif
  endtask

  task automatic test_no_lives();
    applyStimulus(0, 0, 50);
    checks++;
    if (obsX.size() != 0) begin errors++; $display("[TB] FAIL none_writes: got %0d expected 0", obsX.size()); end
    checks++;
    if (doneCyc != 2 || doneCnt != 1) begin errors++; $display("[TB] FAIL none_done: got cycle %0d count %0d expected cycle 2 count 1", doneCyc, doneCnt); end
    checks++;
    if (busyCyc != 2) begin errors++; $display("[TB] FAIL none_busy: got %0d expected 2", busyCyc); end
  endtask

  task automatic test_mixed_lives();
    int d;
    int bad;
    buildExpected(1, 2);
    applyStimulus(1, 2, 3000);
    d = firstSeqDiff();
    checks++;
    if (timedOut || d != -1) begin errors++; $display("[TB] FAIL mixed_stream: timeout=%0d at write %0d got %s expected %s", timedOut, d, seqAt(d, 1), seqAt(d, 0)); end
    checks++;
    if (obsX.size() != 3 * perHeart) begin errors++; $display("[TB] FAIL mixed_count: got %0d expected %0d", obsX.size(), 3 * perHeart); end
    bad = 0;
    for (int i = 0; i < obsX.size(); i++) begin
      if (obsX[i] < 298) begin if (obsY[i] < 86 || obsY[i] > 101) bad++; end
      else if (obsY[i] < 86 || obsY[i] > 119) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL mixed_rows: got %0d out-of-range writes expected 0", bad); end
    checks++;
    if (doneCyc != 2 + 3 * 513) begin errors++; $display("[TB] FAIL mixed_done: got %0d expected %0d", doneCyc, 2 + 3 * 513); end
  endtask

  task automatic test_random_lives();
    int p1, p2, d;
    for (int it = 0; it < 4; it++) begin
      p1 = $urandom_range(0, 3);
      p2 = $urandom_range(0, 3);
      buildExpected(p1, p2);
      applyStimulus(p1, p2, 4000);
      d = firstSeqDiff();
      checks++;
      if (timedOut || d != -1) begin
        errors++; $display("[TB] FAIL rand_stream lives %0d/%0d: timeout=%0d at write %0d got %s expected %s", p1, p2, timedOut, d, seqAt(d, 1), seqAt(d, 0));
      end
      checks++;
      if (doneCyc != 2 + 513 * (p1 + p2) || doneCnt != 1 || busyCyc != doneCyc) begin
        errors++; $display("[TB] FAIL rand_timing lives %0d/%0d: got done %0d count %0d busy %0d expected done %0d count 1 busy %0d",
                           p1, p2, doneCyc, doneCnt, busyCyc, 2 + 513 * (p1 + p2), 2 + 513 * (p1 + p2));
      end
    end
  endtask

  task automatic test_reset_mid_draw();
    int d;
    bit sawDone;
    bit sawWrite;
    @(negedge iCLOCK_50);
    iP1Life = 2'd3; iP2Life = 2'd3; iDrawHearts = 1'b1;
    @(negedge iCLOCK_50);
    iDrawHearts = 1'b0;
    repeat (699) @(negedge iCLOCK_50);
    checks++;
    if (oBusy !== 1'b1 || oy < 8'd104 || oy > 8'd119 || ox > 9'd20) begin
      errors++; $display("[TB] FAIL mid_position: got busy=%b (%0d,%0d) expected busy in P1 slot 1", oBusy, ox, oy);
    end
    ireset = 1'b1;
    @(negedge iCLOCK_50);
    checks++;
    if (owriteEn !== 1'b0 || oBusy !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_abort: got we=%b busy=%b expected 0 0", owriteEn, oBusy);
    end
    ireset = 1'b0;
    sawDone = 0; sawWrite = 0;
    repeat (20) begin
      @(negedge iCLOCK_50);
      if (oDoneSignal) sawDone = 1;
      if (owriteEn) sawWrite = 1;
    end
    checks++;
    if (sawDone || sawWrite) begin
      errors++; $display("[TB] FAIL mid_quiet: got done=%0d write=%0d expected 0 0", sawDone, sawWrite);
    end
    buildExpected(2, 1);
    applyStimulus(2, 1, 3000);
    d = firstSeqDiff();
    checks++;
    if (timedOut || d != -1 || doneCyc != 2 + 3 * 513) begin
      errors++; $display("[TB] FAIL mid_redraw: timeout=%0d diff at %0d got %s expected %s done %0d expected %0d",
                         timedOut, d, seqAt(d, 1), seqAt(d, 0), doneCyc, 2 + 3 * 513);
    end
  endtask

  task automatic test_back_to_back();
    int p2, k, pass1, pass2, done1, done2, fx, fy, t1, t2;
    p2 = $urandom_range(1, 3);
    buildExpected(0, p2);
    t1 = 2 + 513 * (3 + p2);
    t2 = 2 + 513 * p2;
    pass1 = 0; pass2 = 0; done1 = -1; done2 = -1; fx = -1; fy = -1; doneCnt = 0; k = 0;
    @(negedge iCLOCK_50);
    iP1Life = 2'd3; iP2Life = 2'(p2); iDrawHearts = 1'b1;
    while (doneCnt < 2 && k < 9000) begin
      @(negedge iCLOCK_50);
      k++;
      if (k == 600) iP1Life = 2'd0;
      if (owriteEn) begin
        if (doneCnt == 0) pass1++;
        else begin
          if (pass2 == 0) begin fx = int'(ox); fy = int'(oy); end
          pass2++;
        end
      end
      if (oDoneSignal) begin
        doneCnt++;
        if (doneCnt == 1) done1 = k; else begin done2 = k; iDrawHearts = 1'b0; end
      end
    end
    iDrawHearts = 1'b0;
    repeat (3) @(negedge iCLOCK_50);
    checks++;
    if (doneCnt != 2 || oBusy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_passes: got %0d done pulses busy=%b expected 2 and idle", doneCnt, oBusy); end
    checks++;
    if (pass1 != (3 + p2) * perHeart || pass2 != p2 * perHeart) begin
      errors++; $display("[TB] FAIL b2b_writes: got %0d/%0d expected %0d/%0d", pass1, pass2, (3 + p2) * perHeart, p2 * perHeart);
    end
    checks++;
    if (done1 != t1 || done2 != t1 + 1 + t2) begin
      errors++; $display("[TB] FAIL b2b_done: got %0d/%0d expected %0d/%0d", done1, done2, t1, t1 + 1 + t2);
    end
    checks++;
    if (fx != expX[0] || fy != expY[0]) begin
      errors++; $display("[TB] FAIL b2b_first: got (%0d,%0d) expected (%0d,%0d)", fx, fy, expX[0], expY[0]);
    end
  endtask

  initial begin
    ireset = 1'b1; iDrawHearts = 1'b0; iP1Life = 2'd0; iP2Life = 2'd0;
    heartPop = 0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        heartPop += int'(HEART_ROWS[y][x]);
`ifdef HEART_TRANSPARENT_EN
    perHeart = heartPop;
`else
    perHeart = 256;
`endif
    test_reset();
    test_full_lives();
    test_no_lives();
    test_mixed_lives();
    test_random_lives();
    test_reset_mid_draw();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
